// File: rtl/adc_sample_framer.sv
// Decimates two free-running ADC channels and packs 8-bit samples into 16-bit words for the SDRAM write FIFO.
// Latency: 1 input register, wr_en one cycle after the completing tick; no backpressure, words hitting a full FIFO are dropped and flagged.
module adc_sample_framer #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 32
) (
   input  logic                clk50m,
   input  logic                Rst_n,
   input  logic                start,
   input  logic                stop,
   input  logic [CNT_W-1:0]    sample_num,
   input  logic [CNT_W-1:0]    div_set,
   input  logic [1:0]          ch_sel,
   input  logic [DATA_W-1:0]   adc_in1,
   input  logic [DATA_W-1:0]   adc_in2,
   input  logic                wrfifo_full,
   output logic [2*DATA_W-1:0] wr_data,
   output logic                wr_en,
   output logic                busy,
   output logic                done,
   output logic                overflow,
   output logic [CNT_W-1:0]    word_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      RUN  = 2'd2
   } state_t;

   typedef struct packed {
      logic [CNT_W-1:0] num;
      logic [CNT_W-1:0] div;
      logic [1:0]       ch;
   } cfg_t;

   state_t              state_q;
   state_t              state_d;
   cfg_t                cfg_q;
   logic [DATA_W-1:0]   adc1_q;
   logic [DATA_W-1:0]   adc2_q;
   logic [CNT_W-1:0]    div_cnt_q;
   logic                have_first_q;
   logic [DATA_W-1:0]   first_q;

   logic                accept;
   logic                div_last;
   logic                tick;
   logic                issue;
   logic                last;
   logic                zero_done;
   logic [DATA_W-1:0]   smp;
   logic [2*DATA_W-1:0] word;
   logic [CNT_W-1:0]    cnt_inc;

   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      div_last  = (div_cnt_q == (cfg_q.div - CNT_W'(1)));
      tick      = (state_q == RUN) && div_last;
      smp       = cfg_q.ch[0] ? adc2_q : adc1_q;
      word      = cfg_q.ch[1] ? {adc1_q, adc2_q} : {first_q, smp};
      // Single-channel modes only issue on the second sample of a pair.
      issue     = tick && !stop && (cfg_q.ch[1] || have_first_q);
      cnt_inc   = word_cnt + CNT_W'(1);
      last      = issue && (cnt_inc == cfg_q.num);
      zero_done = 1'b0;

      case (state_q)
         IDLE: begin
            if (start && !stop) begin
               state_d   = ARM;
               accept    = 1'b1;
               zero_done = (sample_num == '0);
            end
         end
         ARM: begin
            if (stop || (cfg_q.num == '0)) state_d = IDLE;
            else                           state_d = RUN;
         end
         RUN: begin
            if (stop || last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q != IDLE);

   always_ff @(posedge clk50m or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= IDLE;
         adc1_q  <= '0;
         adc2_q  <= '0;
      end else begin
         state_q <= state_d;
         adc1_q  <= adc_in1;
         adc2_q  <= adc_in2;
      end
   end

   // Config is captured on the accepted start so later input changes are ignored.
   always_ff @(posedge clk50m or negedge Rst_n) begin
      if (!Rst_n) begin
         cfg_q <= '0;
      end else if (accept) begin
         cfg_q.num <= sample_num;
         cfg_q.div <= (div_set == '0) ? CNT_W'(1) : div_set;
         cfg_q.ch  <= ch_sel;
      end
   end

   always_ff @(posedge clk50m or negedge Rst_n) begin
      if (!Rst_n) begin
         div_cnt_q    <= '0;
         have_first_q <= 1'b0;
         first_q      <= '0;
      end else if (state_q != RUN) begin
         div_cnt_q    <= '0;
         have_first_q <= 1'b0;
      end else begin
         div_cnt_q <= div_last ? '0 : div_cnt_q + CNT_W'(1);
         if (tick && !cfg_q.ch[1]) begin
            have_first_q <= !have_first_q;
            if (!have_first_q) first_q <= smp;
         end
      end
   end

   // A dropped word still counts, so the capture length never depends on FIFO state.
   always_ff @(posedge clk50m or negedge Rst_n) begin
      if (!Rst_n) begin
         wr_data  <= '0;
         wr_en    <= 1'b0;
         done     <= 1'b0;
         overflow <= 1'b0;
         word_cnt <= '0;
      end else begin
         wr_en <= issue && !wrfifo_full;
         done  <= zero_done || last;
         if (issue && !wrfifo_full) wr_data <= word;
         if (accept) begin
            word_cnt <= '0;
            overflow <= 1'b0;
         end else if (issue) begin
            word_cnt <= cnt_inc;
            if (wrfifo_full) overflow <= 1'b1;
         end
      end
   end

endmodule
